// File: rtl/ram_dp_bw_banked.sv
// Banked simple-dual-port RAM with byte-lane write enables, write-to-read forwarding and out-of-range flagging.
// Read latency 1 cycle (OUTREG=0) or 2 cycles (OUTREG=1); rd_valid_o marks each completed read.
// No backpressure: every accepted request completes; busy_o (clear sequencer, macro RAM_DP_CLEAR_EN) blocks requests.
module ram_dp_bw_banked #(
  parameter int DW         = 64,
  parameter int BW         = 8,
  parameter int DEPTH      = 1440,
  parameter int BANK_DEPTH = 512,
  parameter int OUTREG     = 0,
  parameter int AW         = $clog2(DEPTH)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               wr_en_i,
  input  logic [DW/BW-1:0]   ben_i,
  input  logic [AW-1:0]      wr_addr_i,
  input  logic [DW-1:0]      wr_data_i,
  input  logic               rd_en_i,
  input  logic [AW-1:0]      rd_addr_i,
  output logic [DW-1:0]      rd_data_o,
  output logic               rd_valid_o,
  output logic               oor_err_o,
  output logic               busy_o
);
  localparam int NB    = DW / BW;
  localparam int NBANK = (DEPTH + BANK_DEPTH - 1) / BANK_DEPTH;
  localparam int OW    = (BANK_DEPTH > 1) ? $clog2(BANK_DEPTH) : 1;
  localparam int BKW   = (NBANK > 1) ? AW - OW : 1;
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic          busy;
  logic          clr_we;
  logic [AW-1:0] clr_addr;

`ifdef RAM_DP_CLEAR_EN
  typedef enum logic {CLEAR, READY} state_e;
  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;

  // Clear sequencer state and address counter; reset restarts the sweep at 0.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Sweep one word per cycle, leave CLEAR after the last address is written.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    clr_we   = 1'b0;
    clr_addr = cnt_q;
    case (state_q)
      CLEAR: begin
        clr_we = 1'b1;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == AW'(DEPTH - 1)) begin
          state_d = READY;
          cnt_d   = '0;
        end
      end
      READY:   state_d = READY;
      default: state_d = CLEAR;
    endcase
  end

  assign busy = (state_q == CLEAR);
`else
  assign busy     = 1'b0;
  assign clr_we   = 1'b0;
  assign clr_addr = '0;
`endif

  assign busy_o = busy;

  logic wr_in, rd_in, usr_we, usr_re, rd_go;
  assign wr_in  = ({1'b0, wr_addr_i} < DEPTH_W);
  assign rd_in  = ({1'b0, rd_addr_i} < DEPTH_W);
  assign usr_we = wr_en_i & ~busy & wr_in;
  assign usr_re = rd_en_i & ~busy;
  assign rd_go  = usr_re & rd_in;

  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [NB-1:0] mem_ben;
  logic [DW-1:0] mem_wdat;

  // Clear sweep owns the write port while busy; a write during reset is suppressed.
  always_comb begin
    mem_we    = usr_we & ~rst_i;
    mem_waddr = wr_addr_i;
    mem_ben   = ben_i;
    mem_wdat  = wr_data_i;
    if (clr_we) begin
      mem_we    = ~rst_i;
      mem_waddr = clr_addr;
      mem_ben   = '1;
      mem_wdat  = '0;
    end
  end

  logic [BKW-1:0] wr_bank, rd_bank;
  logic [OW-1:0]  wr_off, rd_off;

  if (NBANK > 1) begin : g_dec
    assign wr_bank = mem_waddr[AW-1:OW];
    assign wr_off  = mem_waddr[OW-1:0];
    assign rd_bank = rd_addr_i[AW-1:OW];
    assign rd_off  = rd_addr_i[OW-1:0];
  end else begin : g_nodec
    assign wr_bank = '0;
    assign rd_bank = '0;
    assign wr_off  = OW'(mem_waddr);
    assign rd_off  = OW'(rd_addr_i);
  end

  logic [DW-1:0] bank_rd [NBANK];

  for (genvar b = 0; b < NBANK; b++) begin : g_bank
    logic [DW-1:0] mem [BANK_DEPTH];
    logic [DW-1:0] rd_q;
    logic          we_b, re_b;
    assign we_b = mem_we & (wr_bank == BKW'(b));
    assign re_b = rd_go  & (rd_bank == BKW'(b));

    // Per-lane write and registered read of this bank; read returns pre-write contents.
    always_ff @(posedge clk_i) begin
      if (we_b) begin
        for (int k = 0; k < NB; k++) begin
          if (mem_ben[k]) mem[wr_off][k*BW +: BW] <= mem_wdat[k*BW +: BW];
        end
      end
      if (re_b) rd_q <= mem[rd_off];
    end
    assign bank_rd[b] = rd_q;
  end

  logic           rd_v1_q, rd_zero_q, col_q, oor_q;
  logic [BKW-1:0] rd_bank_q;
  logic [NB-1:0]  col_ben_q;
  logic [DW-1:0]  col_dat_q;

  // Read-side tracking: valid, bank select, zero-force and same-address write capture.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_v1_q   <= 1'b0;
      rd_zero_q <= 1'b1;
      rd_bank_q <= '0;
      col_q     <= 1'b0;
      col_ben_q <= '0;
      col_dat_q <= '0;
      oor_q     <= 1'b0;
    end else begin
      rd_v1_q <= usr_re;
      if (usr_re) begin
        rd_zero_q <= ~rd_in;
        if (rd_in) rd_bank_q <= rd_bank;
        col_q     <= usr_we & (wr_addr_i == rd_addr_i);
        col_ben_q <= ben_i;
        col_dat_q <= wr_data_i;
      end
      if (~busy & ((wr_en_i & ~wr_in) | (rd_en_i & ~rd_in))) oor_q <= 1'b1;
    end
  end

  assign oor_err_o = oor_q;

  logic [DW-1:0] merged;

  // Bank mux, write-first lane merge on collision, zero for out-of-range reads.
  always_comb begin
    merged = bank_rd[rd_bank_q];
    for (int k = 0; k < NB; k++) begin
      if (col_q && col_ben_q[k]) merged[k*BW +: BW] = col_dat_q[k*BW +: BW];
    end
    if (rd_zero_q) merged = '0;
  end

  if (OUTREG != 0) begin : g_oreg
    logic [DW-1:0] rd_dat_q;
    logic          rd_vld_q;
    // Optional output stage; captures only completed reads so data holds between them.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        rd_dat_q <= '0;
        rd_vld_q <= 1'b0;
      end else begin
        rd_vld_q <= rd_v1_q;
        if (rd_v1_q) rd_dat_q <= merged;
      end
    end
    assign rd_data_o  = rd_dat_q;
    assign rd_valid_o = rd_vld_q;
  end else begin : g_noreg
    assign rd_data_o  = merged;
    assign rd_valid_o = rd_v1_q;
  end
endmodule

// File: doc/ram_dp_bw_banked.md
Name: ram_dp_bw_banked

Overview:
- Parametrised simple-dual-port RAM with byte-lane write enables and one clock.
- Depth is built from BANK_DEPTH-deep banks; the bank index is decoded from the upper address bits, and the read path muxes banks using a registered bank select.
- Successor of the fixed 64b x 1440 EBR wrapper, generalised in width, depth, bank size and read latency.
- Adds read-valid tracking, per-byte write-to-read forwarding, out-of-range detection and an optional clear-after-reset sequencer.
- Used as line/MCU buffer storage in the JPEG encoder datapath.

Parameters:
- DW, 64, data width in bits; must be a multiple of BW.
- BW, 8, bits per byte lane; NB = DW/BW lanes.
- DEPTH, 1440, number of addressable words.
- BANK_DEPTH, 512, words per bank; power of 2. NBANK = ceil(DEPTH/BANK_DEPTH).
- OUTREG, 0, 0 = 1-cycle read latency; 1 = extra output register, 2-cycle latency.
- AW, $clog2(DEPTH), address width (derived; do not override).

Ports:
- clk_i  in  1  single clock for read and write.
- rst_i  in  1  asynchronous, active-high reset.
- wr_en_i  in  1  write request.
- ben_i  in  NB  byte-lane enables; bit k covers wr_data_i[BW*k +: BW].
- wr_addr_i  in  AW  write word address.
- wr_data_i  in  DW  write data.
- rd_en_i  in  1  read request.
- rd_addr_i  in  AW  read word address.
- rd_data_o  out  DW  read data.
- rd_valid_o  out  1  rd_data_o is valid this cycle.
- oor_err_o  out  1  sticky flag: an out-of-range access occurred.
- busy_o  out  1  clear sequencer active; all requests ignored.

Behaviour:
- Reset values: rd_data_o=0, rd_valid_o=0, oor_err_o=0, registered bank select=0, valid pipeline=0.
- busy_o reset value: 1 if RAM_DP_CLEAR_EN is defined, else 0.
- Memory contents are not reset.
- Write:
  - On a rising edge with wr_en_i=1, busy_o=0 and wr_addr_i<DEPTH, each lane with ben_i[k]=1 is written.
  - Lanes with ben_i[k]=0 keep their old value.
  - ben_i=0 is a no-op.
- Read:
  - rd_en_i=1 with busy_o=0 issues a read.
  - rd_valid_o pulses exactly L=1+OUTREG cycles later with the data; one valid per request, and back-to-back reads give back-to-back valids.
  - When no read completes, rd_valid_o=0 and rd_data_o holds its last value.
- Bank decode:
  - bank = addr / BANK_DEPTH; offset = addr % BANK_DEPTH.
  - Only the selected bank's read/write enable is asserted.
  - The read bank select is registered on rd_en_i and used to mux the bank outputs.
- Collision (rd_en_i and wr_en_i in the same cycle, rd_addr_i==wr_addr_i, both in range):
  - Write-first per byte: enabled lanes return the new data, disabled lanes return the stored data.
  - Implement by registering the write data/enables and merging at the output; the raw bank port mode is not relied on.
- Out of range (addr >= DEPTH):
  - A write is dropped.
  - A read still produces rd_valid_o at latency L, with rd_data_o=0.
  - Either case sets oor_err_o on the next edge; it stays set until rst_i.
- Reset mid-operation: in-flight reads are discarded, no rd_valid_o is produced after reset release, and a write in the reset cycle is not performed.
- OUTREG=1: the collision merge and the out-of-range zeroing happen before the output register.
- Degenerate configuration: DEPTH <= BANK_DEPTH gives a single bank and no decode logic.

Optional Feature:
- Macro: RAM_DP_CLEAR_EN.
- Defined:
  - FSM states CLEAR and READY.
  - Reset enters CLEAR with counter=0 and busy_o=1. Each cycle writes 0 to all lanes at address counter, then increments it.
  - After writing address DEPTH-1 the FSM moves to READY and busy_o drops; this takes exactly DEPTH cycles after reset release.
  - During CLEAR, user wr_en_i/rd_en_i are ignored, no rd_valid_o is produced, and oor_err_o is not updated.
  - Reset during CLEAR restarts the clear at address 0.
- Not defined: no FSM, busy_o tied to 0, contents are undefined until written.

Test Plan:
- Byte-enable write: write 0x1122334455667788 to addr 5 with ben=0xFF, then 0xAAAAAAAAAAAAAAAA with ben=0x0F, read addr 5 -> 0x11223344AAAAAAAA with rd_valid_o 1 cycle after rd_en_i (OUTREG=0) or 2 cycles (OUTREG=1).
- Bank boundaries: write distinct data to addrs 511, 512, 1023, 1024, 1439, read back-to-back -> each value returned in order, no stale bank-mux output, 5 consecutive valid pulses.
- Collision: addr 700 holds 0; same-cycle write 0xFFFF...FF with ben=0x81 and read of 700 -> 0xFF000000000000FF.
- Out of range: write to 1500, then read 1500 -> rd_valid_o asserted, rd_data_o=0, oor_err_o=1 and remains 1; re-reading a valid address still works; rst_i clears oor_err_o.
- Reset mid-read: assert rst_i the cycle after rd_en_i with OUTREG=1 -> rd_valid_o never asserts, rd_data_o=0.
- RAM_DP_CLEAR_EN, DEPTH=1440: busy_o high for 1440 cycles after reset release; reads issued during busy produce no valid; afterwards every address reads 0.
